screen_write_arbiter: RTL and testbench
=======================================

# screen_write_arbiter

Shares the single write port of the character screen memory (read by the VGA display driver) between the game-logic requesters: ship, asteroids, score and status. Uses round-robin arbitration and gates writes to vertical blanking so the frame being scanned out never tears. Also provides a hardware clear-screen sweep and a once-per-frame tick for game-state advance.

## Interface
- NREQ, 4, number of requesters (2..8)
- SCREEN_CELLS, 1200, character cells cleared by the sweep (40x30)
- CLEAR_CHAR, 3'd0, character code written by the sweep
- BLANK_ONLY, 1, 1 = writes only while vblank high; 0 = writes any cycle
- clk  in  1  system/pixel clock shared with the display driver
- reset  in  1  asynchronous, active-high
- vblank  in  1  high during vertical blanking (from display timing)
- req  in  NREQ  per-requester write request, held until ack
- req_addr  in  NREQ*11  packed cell addresses, requester i at [11i+10:11i]
- req_char  in  NREQ*3  packed character codes, requester i at [3i+2:3i]
- ack  out  NREQ  one-hot grant, combinational, at most one bit high
- clear_start  in  1  pulse: start full-screen clear
- clear_busy  out  1  high while sweep in progress
- frame_tick  out  1  one-cycle pulse at start of each vblank
- we  out  1  screen memory write enable (registered)
- wr_addr  out  11  screen memory write address (registered)
- wr_char  out  3  screen memory write data (registered)

## Operation
- States: IDLE (arbitrate requesters), CLEAR (sweep). Reset -> IDLE.
- Write window: win = vblank when BLANK_ONLY=1, else constant 1. No ack and no write outside win.
- IDLE, win high, any req high: grant the first requester at or after rr_ptr, wrapping modulo NREQ. ack[i]=1 that cycle. Next cycle: we=1, wr_addr/wr_char = requester i's data sampled at the grant edge. rr_ptr <= (i+1) mod NREQ.
- Requester handshake: hold req/addr/char stable until it sees ack high at a clock edge. It may then drop req or present new data in the next cycle. Back-to-back grants to different requesters are allowed, one per cycle.
- IDLE with clear_start high: go to CLEAR. clear_start beats any req the same cycle, so no ack is given that cycle. The counter cnt is reset to 0.
- CLEAR: on each win cycle, issue a write of CLEAR_CHAR to cnt and increment cnt. After the write at cnt=SCREEN_CELLS-1, return to IDLE. Outside win, the sweep pauses with cnt held. No acks while in CLEAR. clear_start while in CLEAR is ignored.
- clear_busy = (state==CLEAR), registered.
- frame_tick: registered detection of a vblank 0->1 transition. Pulses for exactly one cycle, one cycle after vblank first samples high.
- Reset at any time, including mid-sweep or mid-grant: state IDLE, rr_ptr=0, cnt=0, we=0, wr_addr=0, wr_char=0, clear_busy=0, frame_tick=0, ack=0. An aborted sweep is not resumed.

## Timing
- Grant-to-write latency: 1 cycle. ack in cycle t, we/wr_addr/wr_char valid in cycle t+1.
- Throughput: 1 write per cycle while win is high.
- Full sweep: exactly SCREEN_CELLS win-cycles. With BLANK_ONLY=0 the sweep takes SCREEN_CELLS cycles, and clear_busy is high for that many cycles starting the cycle after clear_start.
- ack depends combinationally on req, vblank, state and rr_ptr only. There is no path from wr_* to ack.
- vblank is assumed synchronous to clk.

## Structure
- Shared package display_pkg: SCREEN_ADDR_W=11, CHAR_W=3, SCREEN_COLS=40, SCREEN_ROWS=30, the state encoding (ST_IDLE, ST_CLEAR) and CLEAR_CHAR default.
- One sub-module, rr_arbiter: parameter NREQ; inputs req, ptr, enable; outputs one-hot grant and the granted index. The round-robin pointer update stays in the parent.

## Test plan
- BLANK_ONLY=1, vblank=0, req=4'b0001 held 50 cycles -> ack=0 and we=0 throughout. Raise vblank -> ack[0] in the first vblank cycle, we=1 next cycle with the requester's addr/char.
- vblank=1, req=4'b1111 held with distinct addresses -> grants in order 0,1,2,3,0. Each write appears one cycle after its ack with the matching address.
- rr_ptr=2, req=4'b0011 -> requester 0 is granted first, then 1. The skip of empty slots and the wrap are verified.
- BLANK_ONLY=0, clear_start pulse -> 1200 consecutive writes, addresses 0..1199, data 0. clear_busy is high exactly 1200 cycles. req held during the sweep is acked only after clear_busy falls.
- clear_start and req[1] in the same cycle -> no ack that cycle and the sweep starts. A second clear_start mid-sweep has no effect.
- Reset asserted mid-sweep at cnt=600 -> all outputs 0 immediately. After release, clear_busy stays 0 and a new clear_start restarts the sweep at address 0. vblank toggling gives a single-cycle frame_tick per rising edge.

Source files
------------

// File: rtl/display_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// display_pkg
// ----------------------------------------------------------------------------
// Shared character-screen geometry, default clear character and the state
// encoding of the screen write arbiter.
// No ports: package only.
// Revision: 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int SCREEN_ADDR_W   = 11;
  localparam int CHAR_W          = 3;
  localparam int SCREEN_COLS     = 40;
  localparam int SCREEN_ROWS     = 30;
  localparam int SCREEN_CELLS_DEF = SCREEN_COLS * SCREEN_ROWS;

  localparam logic [CHAR_W-1:0] CLEAR_CHAR_DEF = 3'd0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// rr_arbiter
// ----------------------------------------------------------------------------
// Combinational round-robin selector: grants the first requesting slot at or
// after ptr, wrapping modulo NREQ. The pointer itself is owned by the parent.
// Ports:
//   req         in   NREQ   request vector
//   ptr         in   IDX_W  highest-priority slot this cycle
//   enable      in   1      when low no grant is issued
//   grant       out  NREQ   one-hot grant (all zero when nothing granted)
//   grant_idx   out  IDX_W  index of the granted slot
//   grant_valid out  1      a grant was issued
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // overwrites any earlier match and ends up as the winner.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (enable && req[idx]) begin
        grant       = '0;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/screen_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// screen_write_arbiter
// ----------------------------------------------------------------------------
// Shares the character screen memory write port between game-logic
// requesters using round-robin arbitration, optionally restricted to
// vertical blanking. Also provides a full-screen clear sweep and a
// once-per-frame tick.
// Ports:
//   clk         in   1        system/pixel clock
//   reset       in   1        asynchronous, active-high
//   vblank      in   1        vertical blanking indicator
//   req         in   NREQ     per-requester write request (held until ack)
//   req_addr    in   NREQ*11  packed cell addresses
//   req_char    in   NREQ*3   packed character codes
//   ack         out  NREQ     one-hot combinational grant
//   clear_start in   1        start full-screen clear
//   clear_busy  out  1        sweep in progress (registered)
//   frame_tick  out  1        one-cycle pulse at start of each vblank
//   we          out  1        screen memory write enable (registered)
//   wr_addr     out  11       screen memory write address (registered)
//   wr_char     out  3        screen memory write data (registered)
// Revision: 1.0 - initial release
// ============================================================================
module screen_write_arbiter
  import display_pkg::*;
#(
  parameter int                NREQ         = 4,
  parameter int                SCREEN_CELLS = SCREEN_CELLS_DEF,
  parameter logic [CHAR_W-1:0] CLEAR_CHAR   = CLEAR_CHAR_DEF,
  parameter bit                BLANK_ONLY   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vblank,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*SCREEN_ADDR_W-1:0] req_addr,
  input  logic [NREQ*CHAR_W-1:0]        req_char,
  output logic [NREQ-1:0]               ack,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          frame_tick,
  output logic                          we,
  output logic [SCREEN_ADDR_W-1:0]      wr_addr,
  output logic [CHAR_W-1:0]             wr_char
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SCREEN_ADDR_W-1:0] LAST_CELL = SCREEN_ADDR_W'(SCREEN_CELLS - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NREQ - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [SCREEN_ADDR_W-1:0] cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [SCREEN_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0]        wr_char_q, wr_char_d;
  logic                     clear_busy_q, clear_busy_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     vblank_q;

  logic                     win;
  logic                     arb_en;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;

  assign win = BLANK_ONLY ? vblank : 1'b1;

  // Reset is folded in so ack is low for the whole reset interval; a pending
  // clear_start takes the cycle, so requesters are held off.
  assign arb_en = !reset && (state_q == ST_IDLE) && win && !clear_start;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req         (req),
    .ptr         (rr_ptr_q),
    .enable      (arb_en),
    .grant       (ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register and all output/datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_char_q    <= '0;
      clear_busy_q <= 1'b0;
      frame_tick_q <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      wr_char_q    <= wr_char_d;
      clear_busy_q <= clear_busy_d;
      frame_tick_q <= frame_tick_d;
      vblank_q     <= vblank;
    end
  end

  // Next-state logic: sweep counter advances only on window cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (win) begin
          if (cnt_q == LAST_CELL) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SCREEN_ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: write port source select and round-robin pointer update
  always_comb begin
    we_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_char_d    = wr_char_q;
    rr_ptr_d     = rr_ptr_q;
    clear_busy_d = (state_d == ST_CLEAR);
    frame_tick_d = vblank && !vblank_q;
    if ((state_q == ST_CLEAR) && win) begin
      we_d      = 1'b1;
      wr_addr_d = cnt_q;
      wr_char_d = CLEAR_CHAR;
    end else if (grant_valid) begin
      we_d = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          wr_addr_d = req_addr[i*SCREEN_ADDR_W +: SCREEN_ADDR_W];
          wr_char_d = req_char[i*CHAR_W +: CHAR_W];
        end
      end
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  assign we         = we_q;
  assign wr_addr    = wr_addr_q;
  assign wr_char    = wr_char_q;
  assign clear_busy = clear_busy_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_screen_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_screen_write_arbiter
// ----------------------------------------------------------------------------
// Two instances share one stimulus stream: one gated to vblank, one writing
// on any cycle. A frame-level reference model predicts grants, writes, the
// clear sweep and the frame tick for each instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_screen_write_arbiter;
  import display_pkg::*;

  localparam int NREQ  = 4;
  localparam int CELLS = 1200;
  localparam int AW    = SCREEN_ADDR_W;
  localparam int CW    = CHAR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset = 1'b1;
  logic                 vblank = 1'b0;
  logic                 clear_start = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*CW-1:0]   req_char = '0;

  logic [NREQ-1:0] ack_b, ack_a;
  logic            busy_b, busy_a, tick_b, tick_a, we_b, we_a;
  logic [AW-1:0]   wa_b, wa_a;
  logic [CW-1:0]   wc_b, wc_a;

  screen_write_arbiter #(.NREQ(NREQ), .SCREEN_CELLS(CELLS), .CLEAR_CHAR(3'd0), .BLANK_ONLY(1'b1)) u_dut_blank (
    .clk(clk), .reset(reset), .vblank(vblank), .req(req), .req_addr(req_addr), .req_char(req_char),
    .ack(ack_b), .clear_start(clear_start), .clear_busy(busy_b), .frame_tick(tick_b),
    .we(we_b), .wr_addr(wa_b), .wr_char(wc_b));

  screen_write_arbiter #(.NREQ(NREQ), .SCREEN_CELLS(CELLS), .CLEAR_CHAR(3'd0), .BLANK_ONLY(1'b0)) u_dut_any (
    .clk(clk), .reset(reset), .vblank(vblank), .req(req), .req_addr(req_addr), .req_char(req_char),
    .ack(ack_a), .clear_start(clear_start), .clear_busy(busy_a), .frame_tick(tick_a),
    .we(we_a), .wr_addr(wa_a), .wr_char(wc_a));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state, index 0 = vblank-gated instance, 1 = any-cycle
  int m_busy[2], m_cnt[2], m_ptr[2], m_we[2], m_addr[2], m_char[2], m_tick[2], m_vbp[2];
  logic [NREQ-1:0] seen_ack_b;
  logic [NREQ-1:0] seen_ack_a;
  int busy_run_a;

  function automatic bit in_window(int d);
    return (d == 0) ? vblank : 1'b1;
  endfunction

  // Index of the requester the model grants this cycle, -1 for none
  function automatic int pick(int d);
    if (reset || m_busy[d] != 0 || !in_window(d) || clear_start) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr[d] + k) % NREQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_busy[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0; m_we[d] = 0;
    m_addr[d] = 0; m_char[d] = 0; m_tick[d] = 0; m_vbp[d] = 0;
  endtask

  task automatic model_step(input int d, input int g);
    m_tick[d] = (vblank && m_vbp[d] == 0) ? 1 : 0;
    m_vbp[d]  = vblank ? 1 : 0;
    m_we[d]   = 0;
    if (m_busy[d] != 0) begin
      if (in_window(d)) begin
        m_we[d] = 1; m_addr[d] = m_cnt[d]; m_char[d] = 0;
        m_cnt[d]++;
        if (m_cnt[d] == CELLS) begin m_busy[d] = 0; m_cnt[d] = 0; end
      end
    end else if (clear_start) begin
      m_busy[d] = 1; m_cnt[d] = 0;
    end else if (g >= 0) begin
      m_we[d]   = 1;
      m_addr[d] = int'(req_addr[g*AW +: AW]);
      m_char[d] = int'(req_char[g*CW +: CW]);
      m_ptr[d]  = (g + 1) % NREQ;
    end
  endtask

  task automatic cmp_dut(input int d, input int g, input logic [NREQ-1:0] a, input logic w,
                         input logic [AW-1:0] wa, input logic [CW-1:0] wc, input logic b, input logic t);
    string s;
    s = (d == 0) ? "blank" : "any";
    check({"ack_", s}, 32'(a), (g < 0) ? 32'd0 : (32'd1 << g));
    check({"we_", s}, 32'(w), 32'(m_we[d]));
    if (m_we[d] != 0 || reset) begin
      check({"wr_addr_", s}, 32'(wa), 32'(m_addr[d]));
      check({"wr_char_", s}, 32'(wc), 32'(m_char[d]));
    end
    check({"clear_busy_", s}, 32'(b), 32'(m_busy[d]));
    check({"frame_tick_", s}, 32'(t), 32'(m_tick[d]));
  endtask

  // One clock: compare at the falling edge, advance model, return 1 after rise
  task automatic tick();
    int g[2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) model_reset(d);
      g[d] = pick(d);
    end
    cmp_dut(0, g[0], ack_b, we_b, wa_b, wc_b, busy_b, tick_b);
    cmp_dut(1, g[1], ack_a, we_a, wa_a, wc_a, busy_a, tick_a);
    seen_ack_b = ack_b;
    seen_ack_a = ack_a;
    if (busy_a) busy_run_a++;
    if (!reset) for (int d = 0; d < 2; d++) model_step(d, g[d]);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    @(posedge clk); #1;
    do_reset();
    tick();

    // Writes withheld outside vblank, released on the first vblank cycle
    vblank = 1'b0;
    req = 4'b0001;
    req_addr[0 +: AW] = 11'h123;
    req_char[0 +: CW] = 3'd5;
    repeat (50) tick();
    vblank = 1'b1;
    tick();
    check("blank_first_ack", 32'(seen_ack_b), 32'd1);
    check("blank_first_we", 32'(we_b), 32'd1);
    check("blank_first_addr", 32'(wa_b), 32'h123);
    check("blank_first_char", 32'(wc_b), 32'd5);

    // All four requesting: rotation 0,1,2,3,0
    do_reset();
    vblank = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(100 + i);
      req_char[i*CW +: CW] = CW'(i + 1);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_order", 32'(seen_ack_b), 32'd1 << (k % NREQ));
      check("rr_order_addr", 32'(wa_b), 32'(100 + (k % NREQ)));
    end

    // Pointer at 3 after granting slot 2: empty slot skipped, wrap to 0
    do_reset();
    req = 4'b0100;
    tick();
    check("ptr_setup", 32'(seen_ack_b), 32'd4);
    req = 4'b0011;
    tick();
    check("wrap_first", 32'(seen_ack_b), 32'd1);
    tick();
    check("wrap_second", 32'(seen_ack_b), 32'd2);

    // Clear sweep started alongside a request; second start mid-sweep ignored
    do_reset();
    req = 4'b0010;
    req_addr[1*AW +: AW] = 11'h2AA;
    vblank = 1'b1;
    clear_start = 1'b1;
    busy_run_a = 0;
    tick();
    check("start_beats_req", 32'(seen_ack_a), 32'd0);
    clear_start = 1'b0;
    for (int c = 0; c < 6000 && (m_busy[0] != 0 || m_busy[1] != 0); c++) begin
      vblank = 1'($urandom_range(0, 1));
      clear_start = (c == 100) ? 1'b1 : 1'b0;
      tick();
    end
    clear_start = 1'b0;
    check("sweep_done_blank", 32'(busy_b), 32'd0);
    check("sweep_done_any", 32'(busy_a), 32'd0);
    check("sweep_len_any", 32'(busy_run_a), 32'(CELLS));
    vblank = 1'b1;
    repeat (3) tick();

    // Reset in the middle of a sweep, then restart from address 0
    do_reset();
    req = '0;
    vblank = 1'b1;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (600) tick();
    req = 4'b0010;
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_we", 32'(we_a), 32'd0);
    check("rst_addr", 32'(wa_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    tick();
    reset = 1'b0;
    req = '0;
    repeat (5) tick();
    check("rst_no_resume", 32'(busy_a), 32'd0);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick();
    check("restart_we", 32'(we_a), 32'd1);
    check("restart_addr", 32'(wa_a), 32'd0);

    // Random traffic with handshaking requesters, vblank runs, rare clears/resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) vblank = ~vblank;
      clear_start = ($urandom_range(0, 299) == 0);
      reset = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || seen_ack_b[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b0;
          end else begin
            req[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom_range(0, CELLS - 1));
            req_char[i*CW +: CW] = CW'($urandom);
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    clear_start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
